// File: rtl/simon_link_io_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : simon_link_io_if                                           |
// | Brief   : byte-stream link (inbound rx, outbound tx) with handshakes |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface simon_link_io_if;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;

  // master is the host side of the link; slave is the IO block
  modport master (
    output rxData, rxValid, txReady,
    input  rxReady, txData, txValid
  );

  modport slave (
    input  rxData, rxValid, txReady,
    output rxReady, txData, txValid
  );
endinterface
`default_nettype wire

// File: rtl/simon_link_io.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : simon_link_io                                              |
// | Brief   : packet framing between a byte link and a SIMON cipher core |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module simon_link_io #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic                clk,
  input  logic                nR,
  simon_link_io_if.slave      link,
  output logic [1:0][N-1:0]   blockIN,
  output logic [M-1:0][N-1:0] KEY,
  output logic                enc_dec,
  output logic [7:0]          infoIN,
  output logic [7:0]          countIN,
  output logic                newData,
  output logic                newKey,
  input  logic                loadData,
  input  logic                loadKey,
  input  logic                doneData,
  input  logic [1:0][N-1:0]   outData,
  input  logic [7:0]          infoOUT,
  input  logic [7:0]          countOUT,
  output logic                readData
);

  localparam int c_KEY_BYTES  = M * N / 8;
  localparam int c_DATA_BYTES = 2 * N / 8;
  localparam int c_MAX_BYTES  = (c_KEY_BYTES > c_DATA_BYTES) ? c_KEY_BYTES : c_DATA_BYTES;
  localparam int c_CW         = $clog2(c_MAX_BYTES);
  localparam logic [c_CW-1:0] c_KEY_LAST  = c_CW'(c_KEY_BYTES - 1);
  localparam logic [c_CW-1:0] c_DATA_LAST = c_CW'(c_DATA_BYTES - 1);
  localparam int c_TX_BYTES   = 2 + c_DATA_BYTES;
  localparam int c_TW         = $clog2(c_TX_BYTES);
  localparam logic [c_TW-1:0] c_TX_LAST   = c_TW'(c_TX_BYTES - 1);
  localparam int c_SREG_W     = 8 * c_TX_BYTES;

  typedef enum logic [2:0] {
    R_INFO  = 3'd0,
    R_CNT   = 3'd1,
    R_KEY   = 3'd2,
    R_DATA  = 3'd3,
    R_ISSUE = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_ACK  = 2'd1,
    T_SEND = 2'd2
  } tx_state_t;

  rx_state_t           r_rx_state;
  logic [c_CW-1:0]     r_byte_cnt;
  logic [7:0]          r_info;
  logic [7:0]          r_count;
  logic                r_enc_dec;
  logic [M*N-1:0]      r_key;
  logic [2*N-1:0]      r_block;
  logic                r_new_data;
  logic                r_new_key;

  tx_state_t           r_tx_state;
  logic [c_TW-1:0]     r_tx_cnt;
  logic [c_SREG_W-1:0] r_sreg;
  logic                r_tx_valid;
  logic                r_read_data;

  logic w_rx_ready;
  logic w_rx_fire;
  logic w_tx_fire;

  assign w_rx_ready = (r_rx_state != R_ISSUE);
  assign w_rx_fire  = link.rxValid && w_rx_ready;
  assign w_tx_fire  = r_tx_valid && link.txReady;

  // Receive side: words land word 0 first, each word LSB byte first
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      r_rx_state <= R_INFO;
      r_byte_cnt <= '0;
      r_info     <= '0;
      r_count    <= '0;
      r_enc_dec  <= 1'b0;
      r_key      <= '0;
      r_block    <= '0;
      r_new_data <= 1'b0;
      r_new_key  <= 1'b0;
    end else begin
      unique case (r_rx_state)
        R_INFO: begin
          if (w_rx_fire) begin
            r_info     <= link.rxData;
            r_enc_dec  <= link.rxData[0];
            r_byte_cnt <= '0;
            r_rx_state <= R_CNT;
          end
        end
        R_CNT: begin
          if (w_rx_fire) begin
            r_count    <= link.rxData;
            r_byte_cnt <= '0;
            r_rx_state <= r_info[1] ? R_KEY : R_DATA;
          end
        end
        R_KEY: begin
          if (w_rx_fire) begin
            r_key[{r_byte_cnt, 3'b000} +: 8] <= link.rxData;
            if (r_byte_cnt == c_KEY_LAST) begin
              r_byte_cnt <= '0;
              r_rx_state <= R_DATA;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        R_DATA: begin
          if (w_rx_fire) begin
            r_block[{r_byte_cnt, 3'b000} +: 8] <= link.rxData;
            if (r_byte_cnt == c_DATA_LAST) begin
              r_byte_cnt <= '0;
              r_new_data <= 1'b1;
              r_new_key  <= r_info[1];
              r_rx_state <= R_ISSUE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        R_ISSUE: begin
          // Requests drop independently; leave only once both have been seen low
          if (loadData) r_new_data <= 1'b0;
          if (loadKey)  r_new_key  <= 1'b0;
          if (!r_new_data && !r_new_key) begin
            r_byte_cnt <= '0;
            r_rx_state <= R_INFO;
          end
        end
        default: r_rx_state <= R_INFO;
      endcase
    end
  end

  // Transmit side: shift register holds {word1, word0, count, info}, sent low byte first
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      r_tx_state  <= T_IDLE;
      r_tx_cnt    <= '0;
      r_sreg      <= '0;
      r_tx_valid  <= 1'b0;
      r_read_data <= 1'b0;
    end else begin
      unique case (r_tx_state)
        T_IDLE: begin
          if (doneData) begin
            r_sreg      <= {outData, countOUT, infoOUT};
            r_read_data <= 1'b1;
            r_tx_cnt    <= '0;
            r_tx_state  <= T_ACK;
          end
        end
        T_ACK: begin
          if (!doneData) begin
            r_read_data <= 1'b0;
            r_tx_valid  <= 1'b1;
            r_tx_state  <= T_SEND;
          end
        end
        T_SEND: begin
          if (w_tx_fire) begin
            if (r_tx_cnt == c_TX_LAST) begin
              r_tx_valid <= 1'b0;
              r_tx_cnt   <= '0;
              r_tx_state <= T_IDLE;
            end else begin
              r_sreg   <= {8'h00, r_sreg[c_SREG_W-1:8]};
              r_tx_cnt <= r_tx_cnt + 1'b1;
            end
          end
        end
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  assign link.rxReady = w_rx_ready;
  assign link.txData  = r_sreg[7:0];
  assign link.txValid = r_tx_valid;

  assign blockIN  = r_block;
  assign KEY      = r_key;
  assign enc_dec  = r_enc_dec;
  assign infoIN   = r_info;
  assign countIN  = r_count;
  assign newData  = r_new_data;
  assign newKey   = r_new_key;
  assign readData = r_read_data;

endmodule
`default_nettype wire
